// File: rtl/mod_reduce_arbiter.sv
// mod_reduce_arbiter
//   Shares one serial mod-p reducer (p = 2^255-19) between NUM_REQ requesters.
//   Requests are granted round-robin with one operation in flight. The granted
//   operand is launched with a one-cycle red_start. The reducer's result is
//   returned as a tagged response held until resp_ready. A watchdog turns a
//   hung reducer into an error response and a sticky fault.
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_data  per-requester request and operand (slot i at [i*WIDE_IN +: WIDE_IN])
//   req_ready           one-hot single-cycle accept pulse
//   resp_valid/ready    response handshake; resp_id/resp_data/resp_err held while valid
//   red_start/red_a     launch pulse and operand to the reducer
//   red_result/red_done reducer result and its completion pulse
//   busy                controller is not idle
//   fault               sticky watchdog flag, cleared only by reset
module mod_reduce_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDE_IN     = 512,
    parameter int WIDE_MOD    = 255,
    parameter int TIMEOUT_CYC = 1023,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDE_IN-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDE_MOD-1:0]        resp_data,
    output logic                       resp_err,
    output logic                       red_start,
    output logic [WIDE_IN-1:0]         red_a,
    input  logic [WIDE_MOD-1:0]        red_result,
    input  logic                       red_done,
    output logic                       busy,
    output logic                       fault
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef int unsigned uint_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [WIDE_IN-1:0]  r_op;
    logic [WIDE_MOD-1:0] r_res;
    logic                r_err;
    logic                r_resp_valid;
    logic                r_red_start;
    logic                r_busy;
    logic                r_fault;
    logic [TMR_W-1:0]    r_timer;

    logic                w_any;
    logic [ID_W-1:0]     w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic [WIDE_IN-1:0]  w_sel_data;
    logic                w_timeout;

    function automatic logic [ID_W-1:0] f_wrap(input uint_t v);
        uint_t m;
        m = v % uint_t'(NUM_REQ);
        return m[ID_W-1:0];
    endfunction

    // Round-robin scan starting at r_rr_ptr; the first valid requester wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int unsigned k = 0; k < uint_t'(NUM_REQ); k++) begin
            w_idx = f_wrap(uint_t'(r_rr_ptr) + k);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // Accept is combinational so the requester sees it in the grant cycle;
    // it is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (!reset && r_state == S_IDLE && !r_fault && w_any)
            req_ready[w_gnt] = 1'b1;
    end

    assign w_sel_data = req_data[uint_t'(w_gnt) * uint_t'(WIDE_IN) +: WIDE_IN];
    assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op         <= '0;
            r_res        <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_red_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_fault && w_any) begin
                        r_op        <= w_sel_data;
                        r_id        <= w_gnt;
                        r_rr_ptr    <= f_wrap(uint_t'(w_gnt) + 1);
                        r_red_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_red_start <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (red_done) begin
                        r_res        <= red_result;
                        r_err        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_timeout) begin
                        r_res        <= '0;
                        r_err        <= 1'b1;
                        r_fault      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        if (r_fault) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_id;
    assign resp_data  = r_res;
    assign resp_err   = r_err;
    assign red_start  = r_red_start;
    assign red_a      = r_op;
    assign busy       = r_busy;
    assign fault      = r_fault;

endmodule

// File: tb/tb_mod_reduce_arbiter.sv
module tb_mod_reduce_arbiter;

    localparam int N   = 4;
    localparam int WI  = 512;
    localparam int WM  = 255;
    localparam int TMO = 16;
    localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*WI-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [WM-1:0]   resp_data;
    logic            resp_err;
    logic            red_start;
    logic [WI-1:0]   red_a;
    logic [WM-1:0]   red_result;
    logic            red_done;
    logic            busy;
    logic            fault;

    always #5 clk = ~clk;

    mod_reduce_arbiter #(
        .NUM_REQ    (N),
        .WIDE_IN    (WI),
        .WIDE_MOD   (WM),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .red_start (red_start),
        .red_a     (red_a),
        .red_result(red_result),
        .red_done  (red_done),
        .busy      (busy),
        .fault     (fault)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_rr  = 0;
    logic [511:0] ops [N];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(input int i, input logic [511:0] a);
        ops[i] = a;
        req_data[i*WI +: WI] = a;
        req_valid[i] = 1'b1;
    endtask

    // Reference arbitration: first valid index scanning upward from rr, wrapping.
    function automatic int model_grant(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"},  req_ready,  '0);
        chk({tag, "_resp_valid"}, resp_valid, '0);
        chk({tag, "_resp_id"},    resp_id,    '0);
        chk({tag, "_resp_data"},  resp_data,  '0);
        chk({tag, "_resp_err"},   resp_err,   '0);
        chk({tag, "_red_start"},  red_start,  '0);
        chk({tag, "_red_a"},      red_a,      '0);
        chk({tag, "_busy"},       busy,       '0);
        chk({tag, "_fault"},      fault,      '0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        settle;
        chk_zero("rst");
        tick;
        reset = 1'b0;
        m_rr  = 0;
    endtask

    // One complete transaction from the IDLE grant cycle to the response handshake.
    // lat: WAIT cycle in which red_done pulses; lat > TMO means the reducer never answers.
    task automatic serve(input int lat, input int stall, input bit keep);
        int g;
        bit tmo;
        int nw;
        logic [511:0] exp_res;
        logic [N-1:0] exp_rdy;
        settle;
        g = model_grant(req_valid, m_rr);
        if (g < 0) begin
            $display("FAIL serve_setup: observed no pending request expected at least one");
            $fatal(1);
        end
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        chk("req_ready_grant", req_ready, exp_rdy);
        chk("busy_idle", busy, 0);
        m_rr    = (g + 1) % N;
        tmo     = (lat > TMO);
        exp_res = tmo ? 512'd0 : ops[g] % P;
        tick;
        if (!keep) req_valid[g] = 1'b0;
        settle;
        chk("red_start_issue", red_start, 1);
        chk("red_a_issue", red_a, ops[g]);
        chk("req_ready_issue", req_ready, 0);
        chk("busy_issue", busy, 1);
        nw = tmo ? TMO : lat;
        for (int i = 1; i <= nw; i++) begin
            tick;
            red_done   = (i == lat);
            red_result = (i == lat) ? exp_res[WM-1:0] : {WM{1'b1}};
            settle;
            chk("red_start_wait", red_start, 0);
            chk("resp_valid_wait", resp_valid, 0);
        end
        tick;
        red_done   = 1'b0;
        red_result = '0;
        settle;
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, g);
        chk("resp_data", resp_data, exp_res);
        chk("resp_err", resp_err, tmo);
        chk("fault", fault, tmo);
        for (int s = 0; s < stall; s++) begin
            tick;
            // A stray completion while the response is parked must be ignored.
            red_done   = (s == 1);
            red_result = {WM{1'b1}};
            settle;
            chk("stall_resp_valid", resp_valid, 1);
            chk("stall_resp_id", resp_id, g);
            chk("stall_resp_data", resp_data, exp_res);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_red_start", red_start, 0);
        end
        red_done   = 1'b0;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        settle;
        chk("resp_valid_after_hs", resp_valid, 0);
        chk("busy_after_hs", busy, tmo);
    endtask

    initial begin
        logic [N-1:0] mask;

        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        red_result = '0;
        red_done   = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, rnd512());
        repeat (3) tick;
        settle;
        chk_zero("reset");
        req_valid = '0;
        reset     = 1'b0;
        tick;
        settle;
        chk("idle_no_req_ready", req_ready, 0);
        chk("idle_no_busy", busy, 0);

        // p+5 reduces to 5
        set_req(0, P + 512'd5);
        serve(5, 0, 0);

        // all-ones operand reduces to 1443
        set_req(0, {512{1'b1}});
        serve(3, 0, 0);

        // four requesters held valid: grants rotate 0,1,2,3,0 from a fresh pointer
        do_reset;
        for (int i = 0; i < N; i++) set_req(i, 512'(i));
        for (int t = 0; t < 5; t++) serve($urandom_range(1, 8), 0, 1);
        req_valid = '0;

        // long backpressure with a stray red_done
        set_req(1, rnd512());
        serve(4, 20, 0);

        // completion in the same cycle as the watchdog limit
        set_req(2, rnd512());
        serve(TMO, 1, 0);
        chk("fault_after_boundary", fault, 0);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                if (mask[i]) set_req(i, rnd512());
            serve($urandom_range(1, 16), $urandom_range(0, 3), 0);
            req_valid = '0;
        end

        // reset in WAIT after req2 was granted (pointer would otherwise favour req3)
        set_req(2, rnd512());
        settle;
        chk("pre_reset_grant", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        tick;
        tick;
        reset = 1'b1;
        settle;
        chk_zero("mid_wait_reset");
        tick;
        reset = 1'b0;
        m_rr  = 0;
        set_req(2, rnd512());
        set_req(3, rnd512());
        serve(6, 0, 0);
        req_valid = '0;

        // hung reducer: error response, then permanent fault until reset
        set_req(3, rnd512());
        serve(TMO + 100, 2, 0);
        for (int i = 0; i < N; i++) set_req(i, rnd512());
        for (int c = 0; c < 6; c++) begin
            tick;
            settle;
            chk("fault_req_ready", req_ready, 0);
            chk("fault_red_start", red_start, 0);
            chk("fault_sticky", fault, 1);
            chk("fault_busy", busy, 1);
        end
        do_reset;
        req_valid = '0;
        set_req(1, rnd512());
        serve(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
